// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   OP_* : encodings of the i_op sequencing operations.
package pc_seq_pkg;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRC  = 3'd2;
  localparam logic [2:0] OP_BRR  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HOLD = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;  // reserved, executes as INC

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack for the PC sequencer.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears occupancy)
//   push     : write din into entry[level], then level+1 (ignored when full)
//   pop      : level-1 (ignored when empty)
//   din      : return address to push
//   dout     : top entry, entry[level-1], combinational ('0 when empty)
//   level    : current occupancy
//   full     : level == DEPTH
//   empty    : level == 0
module pc_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   din,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [LW-1:0] level_q;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // Entries are indexed by comparison rather than by level_q directly, so
  // the wider occupancy counter never addresses past the array.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (level_q == LW'(i + 1)) dout = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else if (push && !full) begin
      level_q <= level_q + LW'(1);
    end else if (pop && !empty) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Storage is not reset: a reset only discards contents by zeroing level.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rst && push && !full && level_q == LW'(i)) mem_q[i] <= din;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the fetch stage. Each cycle the PC advances,
// jumps, branches (absolute or relative), calls or returns.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   i_stall                   : hold all state, o_taken forced low
//   i_op                      : sequencing operation (OP_* in pc_seq_pkg)
//   i_target                  : absolute target, or signed offset for BRR
//   i_flags, i_csel, i_cinv   : condition = i_flags[i_csel] ^ i_cinv
//   o_Address_Instruction_Bus : registered PC
//   o_taken                   : last update was non-sequential
//   o_stack_level             : return stack occupancy
//   o_err_ovf, o_err_unf      : sticky call-overflow / return-underflow
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 8,
  parameter int unsigned        NFLAGS      = 4,
  parameter int unsigned        STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = '0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_stall,
  input  logic [2:0]                                  i_op,
  input  logic [ADDR_W-1:0]                           i_target,
  input  logic [NFLAGS-1:0]                           i_flags,
  input  logic [((NFLAGS > 1) ? $clog2(NFLAGS) : 1)-1:0] i_csel,
  input  logic                                        i_cinv,
  output logic [ADDR_W-1:0]                           o_Address_Instruction_Bus,
  output logic                                        o_taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]            o_stack_level,
  output logic                                        o_err_ovf,
  output logic                                        o_err_unf
);

  localparam int unsigned CSEL_W = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              taken_q, taken_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              sel_flag, cond;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  pc_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .level (o_stack_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Out-of-range selects fall back to flag 0.
  always_comb begin
    sel_flag = i_flags[0];
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (i_csel == CSEL_W'(i)) sel_flag = i_flags[i];
    end
    cond = sel_flag ^ i_cinv;
  end

  always_comb begin
    pc_inc  = pc_q + ADDR_W'(1);
    pc_d    = pc_q;
    taken_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!i_stall) begin
      case (i_op)
        OP_JMP: begin
          pc_d    = i_target;
          taken_d = 1'b1;
        end
        OP_BRC: begin
          pc_d    = cond ? i_target : pc_inc;
          taken_d = cond;
        end
        OP_BRR: begin
          // Modular add of the raw offset equals adding its sign extension.
          pc_d    = cond ? (pc_q + i_target) : pc_inc;
          taken_d = cond;
        end
        OP_CALL: begin
          if (stk_full) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = i_target;
            taken_d = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_d    = stk_top;
            taken_d = 1'b1;
          end
        end
        OP_HOLD: pc_d = pc_q;
        default: pc_d = pc_inc;  // OP_INC and OP_RSV
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_Address_Instruction_Bus = pc_q;
  assign o_taken                   = taken_q;
  assign o_err_ovf                 = ovf_q;
  assign o_err_unf                 = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
module tb_pc_seq_unit;

  logic       clk = 1'b0;
  logic       rst, stall, cinv;
  logic [2:0] op;
  logic [7:0] tgt;
  logic [3:0] flags;
  logic [1:0] csel;
  logic [7:0] pc;
  logic       taken, ovf, unf;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_seq_unit #(
    .ADDR_W      (8),
    .NFLAGS      (4),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_stall                   (stall),
    .i_op                      (op),
    .i_target                  (tgt),
    .i_flags                   (flags),
    .i_csel                    (csel),
    .i_cinv                    (cinv),
    .o_Address_Instruction_Bus (pc),
    .o_taken                   (taken),
    .o_stack_level             (level),
    .o_err_ovf                 (ovf),
    .o_err_unf                 (unf)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] tgt;
    logic [3:0] flags;
    logic [1:0] csel;
    logic       cinv;
    int         pc, taken, level, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: PC as an integer, stack as a queue.
  int m_pc, m_taken, m_ovf, m_unf;
  int m_stk[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pc, input int e_tk,
                         input int e_lv, input int e_ov, input int e_un);
    chk({tag, ".pc"},    int'(pc),    e_pc);
    chk({tag, ".taken"}, int'(taken), e_tk);
    chk({tag, ".level"}, int'(level), e_lv);
    chk({tag, ".ovf"},   int'(ovf),   e_ov);
    chk({tag, ".unf"},   int'(unf),   e_un);
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] o,
                       input logic [7:0] t, input logic [3:0] f,
                       input logic [1:0] c, input logic ci);
    rst = r; stall = s; op = o; tgt = t; flags = f; csel = c; cinv = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [2:0] o,
                            input logic [7:0] t, input logic [3:0] f,
                            input logic [1:0] c, input logic ci);
    int cond, off;
    cond = int'(f[c] ^ ci);
    off  = (t >= 128) ? int'(t) - 256 : int'(t);
    if (r) begin
      m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    end else if (s) begin
      m_taken = 0;
    end else begin
      m_taken = 0;
      case (int'(o))
        1: begin m_pc = int'(t); m_taken = 1; end
        2: if (cond != 0) begin m_pc = int'(t); m_taken = 1; end
           else m_pc = (m_pc + 1) % 256;
        3: if (cond != 0) begin m_pc = ((m_pc + off) % 256 + 256) % 256; m_taken = 1; end
           else m_pc = (m_pc + 1) % 256;
        4: if (m_stk.size() == 4) begin m_pc = (m_pc + 1) % 256; m_ovf = 1; end
           else begin m_stk.push_back((m_pc + 1) % 256); m_pc = int'(t); m_taken = 1; end
        5: if (m_stk.size() == 0) begin m_pc = (m_pc + 1) % 256; m_unf = 1; end
           else begin m_pc = m_stk.pop_back(); m_taken = 1; end
        6: ;
        default: m_pc = (m_pc + 1) % 256;
      endcase
    end
  endtask

  function automatic vec_t mk(input int o, input int t, input int f, input int c,
                              input int ci, input int e_pc, input int e_tk,
                              input int e_lv, input int e_ov, input int e_un);
    vec_t v;
    v.op = 3'(o); v.tgt = 8'(t); v.flags = 4'(f); v.csel = 2'(c); v.cinv = 1'(ci);
    v.pc = e_pc; v.taken = e_tk; v.level = e_lv; v.ovf = e_ov; v.unf = e_un;
    return v;
  endfunction

  initial begin
    //                 op tgt   flg  cs ci   pc    tk lv ov un
    vecs.push_back(mk(0, 0,    0,   0, 0,  8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,   0, 0,  8'h02, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,   0, 0,  8'h03, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'hFF, 0,   0, 0,  8'hFF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,   0, 0,  8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(2, 'h40, 4,   2, 0,  8'h40, 1, 0, 0, 0));
    vecs.push_back(mk(2, 'h40, 4,   2, 1,  8'h41, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h10, 0,   0, 0,  8'h10, 1, 0, 0, 0));
    vecs.push_back(mk(3, 'hFC, 4,   2, 0,  8'h0C, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h02, 0,   0, 0,  8'h02, 1, 0, 0, 0));
    vecs.push_back(mk(3, 'hFC, 4,   2, 0,  8'hFE, 1, 0, 0, 0));
    vecs.push_back(mk(3, 'hFC, 4,   2, 1,  8'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h05, 0,   0, 0,  8'h05, 1, 0, 0, 0));
    vecs.push_back(mk(4, 'h20, 0,   0, 0,  8'h20, 1, 1, 0, 0));
    vecs.push_back(mk(4, 'h30, 0,   0, 0,  8'h30, 1, 2, 0, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h21, 1, 1, 0, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h06, 1, 0, 0, 0));
    vecs.push_back(mk(6, 'h99, 0,   0, 0,  8'h06, 0, 0, 0, 0));
    vecs.push_back(mk(2, 'h77, 1,   0, 0,  8'h77, 1, 0, 0, 0));
    vecs.push_back(mk(4, 'h10, 0,   0, 0,  8'h10, 1, 1, 0, 0));
    vecs.push_back(mk(4, 'h10, 0,   0, 0,  8'h10, 1, 2, 0, 0));
    vecs.push_back(mk(4, 'h10, 0,   0, 0,  8'h10, 1, 3, 0, 0));
    vecs.push_back(mk(4, 'h10, 0,   0, 0,  8'h10, 1, 4, 0, 0));
    vecs.push_back(mk(4, 'h50, 0,   0, 0,  8'h11, 0, 4, 1, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h11, 1, 3, 1, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h11, 1, 2, 1, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h11, 1, 1, 1, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h78, 1, 0, 1, 0));
    vecs.push_back(mk(5, 0,    0,   0, 0,  8'h79, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0,    0,   0, 0,  8'h7A, 0, 0, 1, 1));
    vecs.push_back(mk(7, 'h33, 0,   0, 0,  8'h7B, 0, 0, 1, 1));

    rst = 1'b1; stall = 1'b0; op = '0; tgt = '0; flags = '0; csel = '0; cinv = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd1, 8'hAA, 4'h0, 2'd0, 1'b0);
    chk_all("reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b0, vecs[i].op, vecs[i].tgt, vecs[i].flags, vecs[i].csel, vecs[i].cinv);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].level,
              vecs[i].ovf, vecs[i].unf);
    end

    // Stall with a stacked entry present: everything holds, taken low.
    drive(1'b0, 1'b0, 3'd4, 8'h60, 4'h0, 2'd0, 1'b0);
    chk_all("pre_stall_call", 8'h60, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3'd1, 8'h80, 4'h0, 2'd0, 1'b0);
      chk_all($sformatf("stall%0d", k), 8'h60, 0, 1, 1, 1);
    end
    // Reset wins over stall and discards the stacked entry.
    drive(1'b1, 1'b1, 3'd1, 8'h80, 4'h0, 2'd0, 1'b0);
    chk_all("rst_in_stall", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 3'd5, 8'h00, 4'h0, 2'd0, 1'b0);
    chk_all("ret_after_rst", 8'h01, 0, 0, 0, 1);

    // Randomised run against the reference model.
    model_step(1'b1, 1'b0, 3'd0, 8'h0, 4'h0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 8'h0, 4'h0, 2'd0, 1'b0);
    chk_all("rnd_reset", m_pc, m_taken, m_stk.size(), m_ovf, m_unf);
    for (int k = 0; k < 600; k++) begin
      logic       r, s, ci;
      logic [2:0] o;
      logic [7:0] t;
      logic [3:0] f;
      logic [1:0] c;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 12);
      o  = 3'($urandom_range(0, 7));
      t  = 8'($urandom);
      f  = 4'($urandom);
      c  = 2'($urandom);
      ci = 1'($urandom);
      model_step(r, s, o, t, f, c, ci);
      drive(r, s, o, t, f, c, ci);
      chk_all($sformatf("rnd%0d", k), m_pc, m_taken, m_stk.size(), m_ovf, m_unf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
